// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//   Time-multiplexed hex display driver for DIGITS common-anode digits.
//   A frame shows every digit once. Each digit gets a slot of SCAN_DIV clocks.
//   The first BLANK_CYC clocks of each slot keep all anodes off, so the
//   previous digit's segments cannot ghost onto the next digit.
//   A new display value is captured by 'load' into a pending register. It
//   becomes visible only at the next frame boundary, so one frame never shows
//   a mix of old and new digits.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   data         DIGITS hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
//   dp_en        per-digit decimal point enable (captured with data)
//   blank_en     per-digit force-off (captured with data)
//   lz_en        leading-zero suppression enable (captured with data)
//   load         1-cycle strobe that captures data/dp_en/blank_en/lz_en
//   an           digit enables, active-low, registered (at most one low)
//   patt         segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_start  1-cycle pulse one clock after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic [DIGITS-1:0]     blank_en,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            patt,
  output logic                  frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Everything that describes one displayed frame travels together.
  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz;
  } disp_cfg_t;

  // ---------------------------------------------------------------------------
  // Hex to 7-segment, active-low {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [7:0] full;
    case (nib)
      4'h0: full = 8'hC0;
      4'h1: full = 8'hF9;
      4'h2: full = 8'hA4;
      4'h3: full = 8'hB0;
      4'h4: full = 8'h99;
      4'h5: full = 8'h92;
      4'h6: full = 8'h82;
      4'h7: full = 8'hF8;
      4'h8: full = 8'h80;
      4'h9: full = 8'h98;
      4'hA: full = 8'h88;
      4'hB: full = 8'h83;
      4'hC: full = 8'hC6;
      4'hD: full = 8'hA1;
      4'hE: full = 8'h86;
      default: full = 8'h8E;
    endcase
    return full[6:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Scan position: cnt counts clocks inside a slot, idx is the digit shown
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Double-buffered display configuration
  //   pend holds the latest load (last one wins); act is what is being shown.
  //   A load on the boundary cycle itself lands in pend and waits a frame.
  // ---------------------------------------------------------------------------
  disp_cfg_t pend;
  disp_cfg_t act;
  logic      pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      act      <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (frame_end && pend_vld) begin
        act <= pend;
      end
      if (load) begin
        pend     <= '{data: data, dp: dp_en, blank: blank_en, lz: lz_en};
        pend_vld <= 1'b1;
      end else if (frame_end) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit off mask
  //   A digit is a leading zero when it and every digit to its left are zero.
  //   Digit 0 is never suppressed, so an all-zero value still shows "0".
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] lead_zero;
  logic [DIGITS-1:0] digit_off;

  // NOTE: every variable driven here gets a value on every path (the running
  // tail_zero is seeded before the loop), so no latch is inferred.
  always_comb begin
    logic tail_zero;
    tail_zero = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail_zero    = tail_zero && (act.data[4*i +: 4] == 4'h0);
      lead_zero[i] = tail_zero && (i != 0);
    end
  end

  assign digit_off = act.blank | (lead_zero & {DIGITS{act.lz}});

  // ---------------------------------------------------------------------------
  // Current-digit selection
  // ---------------------------------------------------------------------------
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_off;
  logic [DIGITS-1:0] an_sel;

  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_off   = 1'b1;
    an_sel    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = act.data[4*i +: 4];
        cur_dp    = act.dp[i];
        cur_off   = digit_off[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, one clock behind (cnt, idx)
  //   wrap_q marks that the last edge wrapped idx to 0; frame_start follows it
  //   so the pulse lines up with the first output cycle of the new frame.
  // ---------------------------------------------------------------------------
  logic wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an          <= '1;
      patt        <= 8'hFF;
      frame_start <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q      <= frame_end;
      frame_start <= wrap_q;
      if ((cnt < BLANK_END) || cur_off) begin
        an   <= '1;
        patt <= 8'hFF;
      end else begin
        an   <= an_sel;
        patt <= {~cur_dp, seg7(cur_digit)};
      end
    end
  end

endmodule
